div_unit_iter: RTL and testbench

- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU. The ALU's single-cycle ripple add/subtract path handles add/sub; this block owns division.
- Performs one restoring-division step per clock using a (WIDTH+1)-bit subtract (invert divisor, carry-in 1).
- The core stalls on busy and writes back result when done pulses.

---
 rtl/div_unit_iter.sv | 154 +++++++++++++++
 tb/tb_div_unit_iter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_iter.sv
// div_unit_iter: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock, then a sign/special-case fix-up cycle.
module div_unit_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH-1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_next;

   logic             rem_sel;
   logic             neg_quo;
   logic             neg_rem;
   logic             div_zero;
   logic             ovf;
   logic [WIDTH-1:0] orig_dvd;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CNT_W-1:0] count;

   logic             signed_op;
   logic             sgn_a;
   logic             sgn_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             ovf_in;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;
   logic             fits;

   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] res_next;

   // Operand preparation: signs and magnitudes of the incoming request.
   always_comb begin
      signed_op = ~op[0];
      sgn_a     = signed_op & dividend[WIDTH-1];
      sgn_b     = signed_op & divisor[WIDTH-1];
      mag_a     = sgn_a ? (~dividend + ONE) : dividend;
      mag_b     = sgn_b ? (~divisor + ONE) : divisor;
      ovf_in    = signed_op & (dividend == MIN_NEG) & (divisor == '1);
   end

   // One restoring step: shift in the next dividend bit, trial subtract.
   always_comb begin
      r_sh = {rem_q, quo_q[WIDTH-1]};
      diff = r_sh + ~{1'b0, dvs_q} + ONE_X;
      fits = ~diff[WIDTH];
   end

   // Final selection with sign correction and special-case overrides.
   always_comb begin
      quo_fix = neg_quo ? (~quo_q + ONE) : quo_q;
      rem_fix = neg_rem ? (~rem_q + ONE) : rem_q;
      if (div_zero) begin
         quo_fix = '1;
         rem_fix = orig_dvd;
      end else if (ovf) begin
         quo_fix = MIN_NEG;
         rem_fix = '0;
      end
      res_next = rem_sel ? rem_fix : quo_fix;
   end

   // Next-state logic and busy flag.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      unique case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (count == LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath registers: latch on start, iterate in CALC, publish in FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_sel  <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         orig_dvd <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         count    <= '0;
         result   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rem_sel  <= op[1];
                  neg_quo  <= sgn_a ^ sgn_b;
                  neg_rem  <= sgn_a;
                  div_zero <= (divisor == '0);
                  ovf      <= ovf_in;
                  orig_dvd <= dividend;
                  rem_q    <= '0;
                  quo_q    <= mag_a;
                  dvs_q    <= mag_b;
                  count    <= '0;
               end
            end
            CALC: begin
               rem_q <= fits ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], fits};
               count <= count + CNT_ONE;
            end
            FIX: begin
               result <= res_next;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit_iter.sv
// tb_div_unit_iter: table vectors, random vectors against a reference
// model, and hand-written handshake / reset sequences with a scoreboard.
module tb_div_unit_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [W-1:0] exp_q[$];
   int           st_q[$];

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
   } vec_t;

   vec_t vt[15];

   div_unit_iter #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] model(input logic [1:0] o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      if (b == '0)
         r = o[1] ? a : '1;
      else if (!o[0] && a == 32'h8000_0000 && b == '1)
         r = o[1] ? '0 : a;
      else begin
         case (o)
            2'b00:   r = $signed(a) / $signed(b);
            2'b01:   r = a / b;
            2'b10:   r = $signed(a) % $signed(b);
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Advance to the next falling edge and score any completed result.
   task automatic tick();
      int s;
      @(negedge clk);
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_done: done=1 with no op pending, result %h",
                     result);
         end else begin
            s = st_q.pop_front();
            chk("result", result, exp_q.pop_front());
            chk("latency", W'(cyc - s), W'(W + 1));
         end
      end
   endtask

   // Called at a falling edge: present one request for one cycle.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e);
      op       = o;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      exp_q.push_back(e);
      st_q.push_back(cyc + 1);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 3 * W) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL timeout: %0d results outstanding, required 0",
                  exp_q.size());
         exp_q.delete();
         st_q.delete();
      end
   endtask

   initial begin
      int n;
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vt[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
      vt[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
      vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
      vt[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
      vt[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
      vt[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
      vt[6]  = '{2'b11, 32'd5,          32'd0,          32'd5};
      vt[7]  = '{2'b01, 32'd0,          32'd0,          32'hFFFF_FFFF};
      vt[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
      vt[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
      vt[10] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
      vt[11] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
      vt[12] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
      vt[13] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14};
      vt[14] = '{2'b11, 32'hFFFF_FFFF,  32'h10,         32'hF};

      rst      = 1'b1;
      start    = 1'b0;
      op       = 2'b00;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy",   W'(busy),   '0);
      chk("reset_done",   W'(done),   '0);
      chk("reset_result", result,     '0);
      rst = 1'b0;
      tick();

      // First op: busy must stay high exactly W+1 sampled cycles.
      issue(2'b01, 32'd100, 32'd7, 32'd14);
      n = 1;
      while (busy && n < 3 * W) begin
         tick();
         if (busy) n++;
      end
      chk("busy_cycles", W'(n), W'(W + 1));
      chk("done_at_busy_fall", W'(done), W'(1));
      wait_done();

      // Table vectors.
      for (int i = 0; i < 15; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, vt[i].r);
         wait_done();
      end

      // Random vectors against the reference model.
      for (int i = 0; i < 16; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         issue(ro, ra, rb, model(ro, ra, rb));
         wait_done();
      end

      // Starts while busy are ignored; inputs may change after E0.
      issue(2'b01, 32'd1000, 32'd10, 32'd100);
      repeat (3) tick();
      op = 2'b00; dividend = 32'd77; divisor = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      dividend = 32'd5; divisor = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 3 * W) begin
         tick();
         n++;
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL done_wait: done=%b required 1", done);
      end

      // Back-to-back: start in the done cycle is accepted.
      issue(2'b11, 32'h0001_2345, 32'h100, 32'h45);
      repeat (10) tick();
      chk("result_held", result, 32'd100);
      wait_done();
      repeat (W + 8) tick();

      // Asynchronous reset mid-calculation aborts the op.
      issue(2'b01, 32'd50, 32'd5, 32'd10);
      repeat (9) tick();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy",   W'(busy), '0);
      chk("abort_done",   W'(done), '0);
      chk("abort_result", result,   '0);
      exp_q.delete();
      st_q.delete();
      tick();
      rst = 1'b0;
      repeat (W + 8) tick();
      chk("post_abort_result", result, '0);

      // Fresh op after reset.
      issue(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
